// File: rtl/fifo_drain_unpacker.sv
// fifo_drain_unpacker: drains a fixed-read-latency synchronous FIFO into a narrow valid/ready lane stream.
// Optional build macro FIFO_DRAIN_STATS_EN adds saturating stat_words / stat_stall counters.
module fifo_drain_unpacker #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int RD_LAT    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_rd_en,
    input  logic                 enable,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]          stat_words,
    output logic [31:0]          stat_stall
`endif
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(BUF_DEPTH);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [IN_WIDTH-1:0]  mem_r [BUF_DEPTH];
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CW-1:0]        occ_r, inflight_r, occ_next_s, inflight_next_s;
    logic [CW:0]          credit_sum_s;
    logic [RD_LAT-1:0]    sr_r, sr_next_s;
    logic [LW-1:0]        lane_r, lane_next_s;
    logic                 capture_s, pop_s, xfer_s;
    logic [IN_WIDTH-1:0]  head_next_s;
    logic                 m_valid_r, m_last_r, busy_r;
    logic [OUT_WIDTH-1:0] m_data_r;

    function automatic logic [OUT_WIDTH-1:0] lane_sel(input logic [IN_WIDTH-1:0] word,
                                                      input logic [LW-1:0]       idx);
        logic [IN_WIDTH-1:0] shifted;
        shifted = word >> (int'(idx) * OUT_WIDTH);
        return shifted[OUT_WIDTH-1:0];
    endfunction

    // Read issue, latency tracking and next-state buffer bookkeeping
    always_comb begin
        credit_sum_s    = {1'b0, occ_r} + {1'b0, inflight_r};
        fifo_rd_en      = enable & ~fifo_empty & (credit_sum_s < DEPTH_C);
        capture_s       = sr_r[RD_LAT-1];
        sr_next_s       = sr_r << 1'b1;
        sr_next_s[0]    = fifo_rd_en;
        inflight_next_s = inflight_r + CW'(fifo_rd_en) - CW'(capture_s);
        xfer_s          = m_valid_r & m_ready;
        pop_s           = 1'b0;
        lane_next_s     = lane_r;
        if (xfer_s) begin
            if (lane_r == LAST_LANE) begin
                lane_next_s = {LW{1'b0}};
                pop_s       = 1'b1;
            end else begin
                lane_next_s = lane_r + LW'(1'b1);
            end
        end else begin
            lane_next_s = lane_r;
        end
        case ({capture_s, pop_s})
            2'b10:   occ_next_s = occ_r + CW'(1'b1);
            2'b01:   occ_next_s = occ_r - CW'(1'b1);
            default: occ_next_s = occ_r;
        endcase
        wr_ptr_next_s = capture_s ? (wr_ptr_r + PW'(1'b1)) : wr_ptr_r;
        rd_ptr_next_s = pop_s ? (rd_ptr_r + PW'(1'b1)) : rd_ptr_r;
        // The next head is the word landing this cycle when nothing older remains
        if (capture_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = fifo_data;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Control state and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            occ_r      <= {CW{1'b0}};
            inflight_r <= {CW{1'b0}};
            sr_r       <= {RD_LAT{1'b0}};
            lane_r     <= {LW{1'b0}};
            m_valid_r  <= 1'b0;
            m_data_r   <= {OUT_WIDTH{1'b0}};
            m_last_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            occ_r      <= occ_next_s;
            inflight_r <= inflight_next_s;
            sr_r       <= sr_next_s;
            lane_r     <= lane_next_s;
            m_valid_r  <= (occ_next_s != {CW{1'b0}});
            m_data_r   <= (occ_next_s != {CW{1'b0}}) ? lane_sel(head_next_s, lane_next_s)
                                                     : {OUT_WIDTH{1'b0}};
            m_last_r   <= (occ_next_s != {CW{1'b0}}) && (lane_next_s == LAST_LANE);
            busy_r     <= (occ_next_s != {CW{1'b0}}) || (inflight_next_s != {CW{1'b0}});
        end
    end

    // Word storage; entries are only read after being written, so no reset
    always_ff @(posedge clk) begin
        if (capture_s) begin
            mem_r[wr_ptr_r] <= fifo_data;
        end
    end

    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;
    assign busy    = busy_r;

`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] stat_words_r, stat_stall_r;

    // Saturating counters of words read and downstream stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words_r <= 32'h0000_0000;
            stat_stall_r <= 32'h0000_0000;
        end else begin
            if (fifo_rd_en && (stat_words_r != 32'hFFFF_FFFF)) begin
                stat_words_r <= stat_words_r + 32'h0000_0001;
            end
            if (m_valid_r && !m_ready && (stat_stall_r != 32'hFFFF_FFFF)) begin
                stat_stall_r <= stat_stall_r + 32'h0000_0001;
            end
        end
    end

    assign stat_words = stat_words_r;
    assign stat_stall = stat_stall_r;
`endif

    fifo_drain_unpacker_chk #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture_s),
        .pop        (pop_s),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .occ        (occ_r)
    );
endmodule

// Safety checker: buffer overflow and reads against an empty FIFO are design bugs.
module fifo_drain_unpacker_chk #(
    parameter int BUF_DEPTH = 4,
    parameter int CW        = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          capture,
    input logic          pop,
    input logic          fifo_empty,
    input logic          fifo_rd_en,
    input logic [CW-1:0] occ
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && !pop && (occ == CW'(BUF_DEPTH))));
    a_no_empty_read: assert property (@(posedge clk) disable iff (rst)
        !(fifo_rd_en && fifo_empty));
endmodule

// File: tb/tb_fifo_drain_unpacker.sv
// Bench for fifo_drain_unpacker: FIFO model with fixed read latency, lane scoreboard, directed and random phases.
module tb_fifo_drain_unpacker;
    localparam int IW = 64, OW = 16, RL = 2, BD = 4, RATIO = IW / OW;

    logic          clk = 1'b0;
    logic          rst, enable, m_ready;
    logic          fifo_empty, fifo_rd_en, m_valid, m_last, busy;
    logic [IW-1:0] fifo_data;
    logic [OW-1:0] m_data;

    always #5 clk = ~clk;

    fifo_drain_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .RD_LAT(RL), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .enable(enable), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    // FIFO model: storage array plus RL-deep read data pipeline
    logic [IW-1:0] fmem [0:4095];
    int            fhead = 0, ftail = 0;
    logic [IW-1:0] pipe [RL];
    assign fifo_empty = (fhead == ftail);
    assign fifo_data  = pipe[RL-1];

    always @(posedge clk) begin
        if (rst) begin
            fhead <= ftail;
            for (int i = 0; i < RL; i++) pipe[i] <= '0;
        end else begin
            if (fifo_rd_en && !fifo_empty) begin
                pipe[0] <= fmem[fhead];
                fhead   <= fhead + 1;
            end else begin
                pipe[0] <= '0;
            end
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Scoreboard: expected lanes in order, observed lanes with their cycle numbers
    logic [OW-1:0] exp_d[$];
    logic          exp_l[$];
    logic [OW-1:0] obs_d[$];
    logic          obs_l[$];
    int            obs_c[$];
    int            total = 0, bad = 0, cyc = 0, rd_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [IW-1:0] w);
        logic [IW-1:0] t;
        fmem[ftail] = w;
        ftail++;
        t = w;
        for (int i = 0; i < RATIO; i++) begin
            exp_d.push_back(t[OW-1:0]);
            exp_l.push_back(i == RATIO - 1);
            t = t >> OW;
        end
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_l.delete(); obs_c.delete();
    endtask

    // Per-cycle compare against the scoreboard, sampled mid-cycle
    logic          hold_v = 1'b0, hold_l;
    logic [OW-1:0] hold_d;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                rd_cnt++;
                chk("rd_en_while_empty", fifo_empty, 1'b0);
            end
            if (m_valid) chk("busy_with_valid", busy, 1'b1);
            if (hold_v) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, hold_d);
                chk("hold_last", m_last, hold_l);
            end
            if (m_valid && m_ready) begin
                chk("lane_pending", exp_d.size() > 0, 1'b1);
                if (exp_d.size() > 0) begin
                    chk("lane_data", m_data, exp_d.pop_front());
                    chk("lane_last", m_last, exp_l.pop_front());
                end
                obs_d.push_back(m_data);
                obs_l.push_back(m_last);
                obs_c.push_back(cyc);
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_d.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, (exp_d.size() == 0) && !busy, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] w;
        int rd0, n, n0;
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 16'h0000);
        chk("rst_last", m_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single known word, lanes 1..4 back to back
        clear_obs();
        enable = 1'b1; m_ready = 1'b1;
        push(64'h0004_0003_0002_0001);
        drain("t1_drain", 50);
        chk("t1_count", obs_d.size(), 4);
        if (obs_d.size() == 4) begin
            chk("t1_lane0", obs_d[0], 16'h0001);
            chk("t1_lane1", obs_d[1], 16'h0002);
            chk("t1_lane2", obs_d[2], 16'h0003);
            chk("t1_lane3", obs_d[3], 16'h0004);
            chk("t1_last", {obs_l[0], obs_l[1], obs_l[2], obs_l[3]}, 4'b0001);
            chk("t1_gapless", obs_c[3] - obs_c[0], 3);
        end

        // 2: eight words, 32 lanes with no gaps
        clear_obs();
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) push({$urandom(), $urandom()});
        drain("t2_drain", 200);
        chk("t2_reads", rd_cnt - rd0, 8);
        chk("t2_count", obs_d.size(), 32);
        if (obs_d.size() == 32) chk("t2_gapless", obs_c[31] - obs_c[0], 31);

        // 3: downstream stalled; reads stop at buffer depth
        m_ready = 1'b0;
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) push({$urandom(), $urandom()});
        repeat (20) tick();
        chk("t3_reads", rd_cnt - rd0, BD);
        chk("t3_rd_en_off", fifo_rd_en, 1'b0);
        chk("t3_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        drain("t3_drain", 200);

        // 4: FIFO runs empty mid-stream, then refills
        for (int i = 0; i < 3; i++) push({$urandom(), $urandom()});
        for (int i = 0; i < 60; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("t4_empty", fifo_empty, 1'b1);
        chk("t4_rd_en_off", fifo_rd_en, 1'b0);
        m_ready = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 2; i++) push({$urandom(), $urandom()});
        drain("t4_drain", 100);

        // 5: enable dropped with two reads in flight
        enable = 1'b0;
        for (int i = 0; i < 6; i++) push({$urandom(), $urandom()});
        tick();
        chk("t5_idle_rd_en", fifo_rd_en, 1'b0);
        rd0 = rd_cnt;
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        n = 0;
        while (exp_d.size() > 16 && n < 40) begin tick(); n++; end
        chk("t5_delivered", exp_d.size(), 16);
        chk("t5_busy_falls", busy, 1'b0);
        chk("t5_reads", rd_cnt - rd0, 2);
        repeat (5) tick();
        chk("t5_still_held", exp_d.size(), 16);
        enable = 1'b1;
        drain("t5_drain", 100);

        // 6: reset while lane 2 of a word is presented
        m_ready = 1'b0;
        push({$urandom(), $urandom()});
        n = 0;
        while (!m_valid && n < 20) begin tick(); n++; end
        chk("t6_valid", m_valid, 1'b1);
        n0 = obs_d.size();
        m_ready = 1'b1;
        n = 0;
        while (obs_d.size() < n0 + 2 && n < 20) begin tick(); n++; end
        chk("t6_two_lanes", obs_d.size() - n0, 2);
        rst = 1'b1; m_ready = 1'b0;
        exp_d.delete(); exp_l.delete();
        tick();
        chk("t6_rst_valid", m_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_rd_en", fifo_rd_en, 1'b0);
        rst = 1'b0;
        clear_obs();
        w = {$urandom(), $urandom()};
        push(w);
        m_ready = 1'b1;
        drain("t6_drain", 50);
        if (obs_d.size() > 0) chk("t6_first_lane", obs_d[0], w[OW-1:0]);

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) push({$urandom(), $urandom()});
            m_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 7) != 0);
            tick();
        end
        enable = 1'b1; m_ready = 1'b1;
        drain("rand_drain", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
